// File: rtl/beta_pkg.sv
// rtl/beta_pkg.sv - shared types and helpers for the beta issue scoreboard
package beta_pkg;

  typedef enum logic [0:0] {
    SB_RUN   = 1'b0,
    SB_DRAIN = 1'b1
  } sb_state_t;

  localparam int SB_INFLIGHT_W = 4;

  // Number of architectural registers tracked for a given profile.
  function automatic int SB_NUM_REGS(input bit embedded);
    return embedded ? 16 : 32;
  endfunction

  // A register address takes part in hazard tracking only if it is not x0
  // and, in the embedded profile, lies inside the 16-register file.
  function automatic logic sb_addr_live(input logic [4:0] addr, input bit embedded);
    return (addr != 5'd0) && (!embedded || (addr < 5'd16));
  endfunction

endpackage

// File: rtl/beta_sb_regcnt.sv
// rtl/beta_sb_regcnt.sv - per-register pending-write counter array
// Ports: clk_i/rst_i (sync, active-high); alloc_en_i/alloc_addr_i allocate one
// pending write; ret_en_i/ret_addr_i request a retire; rs1/rs2/rd_addr_i read
// ports with *_cnt_o results; ret_done_o a retire took effect; zero_retire_o a
// retire hit a counter already at zero.
module beta_sb_regcnt
  import beta_pkg::*;
#(
  parameter bit Embedded = 1'b0,
  parameter int CntWidth = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_en_i,
  input  logic [4:0]          alloc_addr_i,
  input  logic                ret_en_i,
  input  logic [4:0]          ret_addr_i,
  input  logic [4:0]          rs1_addr_i,
  input  logic [4:0]          rs2_addr_i,
  input  logic [4:0]          rd_addr_i,
  output logic [CntWidth-1:0] rs1_cnt_o,
  output logic [CntWidth-1:0] rs2_cnt_o,
  output logic [CntWidth-1:0] rd_cnt_o,
  output logic                ret_done_o,
  output logic                zero_retire_o
);

  localparam int NumRegs = SB_NUM_REGS(Embedded);
  localparam int IdxW    = $clog2(NumRegs);

  logic [CntWidth-1:0] cnt [NumRegs];
  logic [CntWidth-1:0] ret_cnt;
  logic                ret_live;

  // Non-live addresses (x0, out-of-profile) always read as zero pending.
  assign rs1_cnt_o = sb_addr_live(rs1_addr_i, Embedded) ? cnt[rs1_addr_i[IdxW-1:0]] : '0;
  assign rs2_cnt_o = sb_addr_live(rs2_addr_i, Embedded) ? cnt[rs2_addr_i[IdxW-1:0]] : '0;
  assign rd_cnt_o  = sb_addr_live(rd_addr_i,  Embedded) ? cnt[rd_addr_i[IdxW-1:0]]  : '0;

  assign ret_live      = ret_en_i && sb_addr_live(ret_addr_i, Embedded);
  assign ret_cnt       = cnt[ret_addr_i[IdxW-1:0]];
  assign ret_done_o    = ret_live && (ret_cnt != '0);
  assign zero_retire_o = ret_live && (ret_cnt == '0);

  // alloc_en_i is already qualified by the caller with a live rd.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NumRegs; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NumRegs; r++) begin
        if (alloc_en_i && (alloc_addr_i[IdxW-1:0] == IdxW'(r)) &&
            !(ret_done_o && (ret_addr_i[IdxW-1:0] == IdxW'(r)))) begin
          cnt[r] <= cnt[r] + CntWidth'(1);
        end else if (ret_done_o && (ret_addr_i[IdxW-1:0] == IdxW'(r)) &&
                     !(alloc_en_i && (alloc_addr_i[IdxW-1:0] == IdxW'(r)))) begin
          cnt[r] <= cnt[r] - CntWidth'(1);
        end
      end
    end
  end

endmodule

// File: rtl/beta_issue_scoreboard.sv
// rtl/beta_issue_scoreboard.sv - RAW hazard scoreboard and decode-to-execute issue gate
// Ports: clk_i/rst_i (sync, active-high); iss_* decode instruction and
// iss_ready_o/dec_stall_o issue handshake; wb_valid_i/wb_rd_addr_i writeback
// retire; flush_i enters drain; inflight_o outstanding writes; sb_busy_o not
// idle; sb_err_o sticky writeback-without-pending-write error.
// Option macro BETA_SB_WAW_CHECK_EN: at most one outstanding write per register.
module beta_issue_scoreboard
  import beta_pkg::*;
#(
  parameter bit Embedded    = 1'b0,
  parameter int MaxInFlight = 4,
  parameter int CntWidth    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     iss_valid_i,
  input  logic [4:0]               iss_rs1_addr_i,
  input  logic [4:0]               iss_rs2_addr_i,
  input  logic                     iss_rs1_used_i,
  input  logic                     iss_rs2_used_i,
  input  logic [4:0]               iss_rd_addr_i,
  input  logic                     iss_rd_wr_i,
  output logic                     iss_ready_o,
  output logic                     dec_stall_o,
  input  logic                     wb_valid_i,
  input  logic [4:0]               wb_rd_addr_i,
  input  logic                     flush_i,
  output logic [SB_INFLIGHT_W-1:0] inflight_o,
  output logic                     sb_busy_o,
  output logic                     sb_err_o
);

  sb_state_t                state;
  logic [SB_INFLIGHT_W-1:0] inflight;
  logic [SB_INFLIGHT_W-1:0] inflight_nxt;
  logic                     err;
  logic [CntWidth-1:0]      rs1_cnt, rs2_cnt, rd_cnt;
  logic                     rd_live, rd_ok, alloc, ret_done, zero_retire;
  logic                     haz_rs1, haz_rs2, cap_ok;

  beta_sb_regcnt #(
    .Embedded (Embedded),
    .CntWidth (CntWidth)
  ) u_regcnt (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_en_i    (alloc),
    .alloc_addr_i  (iss_rd_addr_i),
    .ret_en_i      (wb_valid_i),
    .ret_addr_i    (wb_rd_addr_i),
    .rs1_addr_i    (iss_rs1_addr_i),
    .rs2_addr_i    (iss_rs2_addr_i),
    .rd_addr_i     (iss_rd_addr_i),
    .rs1_cnt_o     (rs1_cnt),
    .rs2_cnt_o     (rs2_cnt),
    .rd_cnt_o      (rd_cnt),
    .ret_done_o    (ret_done),
    .zero_retire_o (zero_retire)
  );

  assign rd_live = iss_rd_wr_i && sb_addr_live(iss_rd_addr_i, Embedded);
  assign haz_rs1 = iss_rs1_used_i && (rs1_cnt != '0);
  assign haz_rs2 = iss_rs2_used_i && (rs2_cnt != '0);
  assign cap_ok  = inflight < SB_INFLIGHT_W'(MaxInFlight);

`ifdef BETA_SB_WAW_CHECK_EN
  assign rd_ok = !rd_live || (rd_cnt == '0);
`else
  assign rd_ok = !rd_live || (rd_cnt != '1);
`endif

  // Ready never looks at wb_*: a retire only unblocks issue on the next cycle.
  assign iss_ready_o = (state == SB_RUN) && !flush_i && !haz_rs1 && !haz_rs2 && cap_ok && rd_ok;
  assign dec_stall_o = iss_valid_i && !iss_ready_o;
  assign alloc       = iss_valid_i && iss_ready_o && rd_live;

  // Simultaneous allocate and retire cancel in the global count.
  always_comb begin
    inflight_nxt = inflight;
    if (alloc && !ret_done)      inflight_nxt = inflight + SB_INFLIGHT_W'(1);
    else if (!alloc && ret_done) inflight_nxt = inflight - SB_INFLIGHT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= SB_RUN;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (zero_retire) err <= 1'b1;
      case (state)
        SB_RUN:   if (flush_i) state <= SB_DRAIN;
        SB_DRAIN: if (inflight_nxt == '0) state <= SB_RUN;
        default:  state <= SB_RUN;
      endcase
    end
  end

  assign inflight_o = inflight;
  assign sb_busy_o  = (state != SB_RUN) || (inflight != '0);
  assign sb_err_o   = err;

endmodule

// File: tb/tb_beta_issue_scoreboard.sv
// tb/tb_beta_issue_scoreboard.sv - self-checking bench for beta_issue_scoreboard
module tb_beta_issue_scoreboard;

`ifdef BETA_SB_WAW_CHECK_EN
  localparam bit WAW = 1'b1;
`else
  localparam bit WAW = 1'b0;
`endif
  localparam int MAXF   = 4;
  localparam int CNTMAX = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       iss_valid, rs1_used, rs2_used, rd_wr, wb_valid, flush;
  logic [4:0] rs1_addr, rs2_addr, rd_addr, wb_rd_addr;
  logic       iss_ready, dec_stall, sb_busy, sb_err;
  logic [3:0] inflight;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  beta_issue_scoreboard dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .iss_valid_i    (iss_valid),
    .iss_rs1_addr_i (rs1_addr),
    .iss_rs2_addr_i (rs2_addr),
    .iss_rs1_used_i (rs1_used),
    .iss_rs2_used_i (rs2_used),
    .iss_rd_addr_i  (rd_addr),
    .iss_rd_wr_i    (rd_wr),
    .iss_ready_o    (iss_ready),
    .dec_stall_o    (dec_stall),
    .wb_valid_i     (wb_valid),
    .wb_rd_addr_i   (wb_rd_addr),
    .flush_i        (flush),
    .inflight_o     (inflight),
    .sb_busy_o      (sb_busy),
    .sb_err_o       (sb_err)
  );

  typedef struct {
    bit rst; bit v; int rs1; bit u1; int rs2; bit u2; int rd; bit wr;
    bit wbv; int wbrd; bit fl;
    bit e_rdy; int e_inf; bit e_busy; bit e_err;
  } vec_t;

  vec_t tbl[$];

  // Reference model: plain counts per register, a drain flag and an error flag.
  int m_cnt[32];
  int m_inf;
  bit m_drain;
  bit m_err;

  function automatic vec_t mk(bit r, bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wr,
                              bit wbv, int wbrd, bit fl, bit e_rdy, int e_inf, bit e_busy, bit e_err);
    vec_t x;
    x.rst = r; x.v = v; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2; x.rd = rd; x.wr = wr;
    x.wbv = wbv; x.wbrd = wbrd; x.fl = fl;
    x.e_rdy = e_rdy; x.e_inf = e_inf; x.e_busy = e_busy; x.e_err = e_err;
    return x;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    rst = x.rst; iss_valid = x.v;
    rs1_addr = 5'(x.rs1); rs1_used = x.u1;
    rs2_addr = 5'(x.rs2); rs2_used = x.u2;
    rd_addr = 5'(x.rd); rd_wr = x.wr;
    wb_valid = x.wbv; wb_rd_addr = 5'(x.wbrd); flush = x.fl;
  endtask

  function automatic bit model_ready(vec_t x);
    if (m_drain || x.fl) return 1'b0;
    if (x.u1 && x.rs1 != 0 && m_cnt[x.rs1] > 0) return 1'b0;
    if (x.u2 && x.rs2 != 0 && m_cnt[x.rs2] > 0) return 1'b0;
    if (m_inf >= MAXF) return 1'b0;
    if (x.wr && x.rd != 0) begin
      if (WAW && m_cnt[x.rd] != 0) return 1'b0;
      if (m_cnt[x.rd] >= CNTMAX) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_inf = 0; m_drain = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(vec_t x);
    bit rdy, ret;
    if (x.rst) begin
      model_reset();
      return;
    end
    rdy = model_ready(x);
    ret = 1'b0;
    if (x.wbv && x.wbrd != 0) begin
      if (m_cnt[x.wbrd] == 0) m_err = 1'b1;
      else ret = 1'b1;
    end
    if (x.v && rdy && x.wr && x.rd != 0) begin
      m_cnt[x.rd]++;
      m_inf++;
    end
    if (ret) begin
      m_cnt[x.wbrd]--;
      m_inf--;
    end
    if (!m_drain) m_drain = x.fl;
    else if (m_inf == 0) m_drain = 1'b0;
  endtask

  vec_t idle;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0, 0,0,0, 1,0,0,0);
    drive(idle);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    //                  rst v rs1 u1 rs2 u2 rd wr  wbv wbrd fl   rdy inf busy err
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  0, 0,0,  1,0,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 5,1,  0, 0,0,  1,0,0,0));
    tbl.push_back(mk(0,1, 5,1, 0,0, 6,1,  0, 0,0,  0,1,1,0));
    tbl.push_back(mk(0,1, 5,1, 0,0, 6,1,  1, 5,0,  0,1,1,0));
    tbl.push_back(mk(0,1, 5,1, 0,0, 6,1,  0, 0,0,  1,0,0,0));
    tbl.push_back(mk(0,1, 0,0, 6,0, 0,1,  0, 0,0,  1,1,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  0, 0,0,  1,1,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  1, 6,0,  1,1,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 1,1,  0, 0,0,  1,0,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 2,1,  0, 0,0,  1,1,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 3,1,  0, 0,0,  1,2,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 4,1,  0, 0,0,  1,3,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 8,1,  0, 0,0,  0,4,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 8,1,  1, 2,0,  0,4,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 8,1,  0, 0,0,  1,3,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  1, 1,0,  0,4,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  1, 3,0,  1,3,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  1, 4,0,  1,2,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  1, 8,0,  1,1,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1,  0, 0,0,  1,0,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1,  1, 7,0,  !WAW,1,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  !WAW,7,0, 1,WAW?0:1,!WAW,0));
    tbl.push_back(mk(0,1, 7,1, 0,0, 0,0,  0, 0,0,  1,0,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0,10,1,  0, 0,0,  1,0,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0,11,1,  0, 0,0,  1,1,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0,12,1,  0, 0,1,  0,2,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0,12,1,  0, 0,0,  0,2,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  1,10,1,  0,2,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  1,11,0,  0,1,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  0, 0,0,  1,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  1, 9,0,  1,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  0, 0,0,  1,0,0,1));
    tbl.push_back(mk(0,1, 0,0, 0,0,13,1,  0, 0,0,  1,0,0,1));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  0, 0,1,  0,1,1,1));
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,  0, 0,0,  0,1,1,1));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  0, 0,0,  1,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  1,13,0,  1,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  0, 0,0,  1,0,0,1));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  0, 0,1,  0,0,0,1));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  0, 0,0,  0,0,1,1));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,  0, 0,0,  1,0,0,1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      check($sformatf("tbl%0d ready", i), iss_ready, tbl[i].e_rdy);
      check($sformatf("tbl%0d stall", i), dec_stall, tbl[i].v && !tbl[i].e_rdy);
      check($sformatf("tbl%0d inflight", i), inflight, tbl[i].e_inf);
      check($sformatf("tbl%0d busy", i), sb_busy, tbl[i].e_busy);
      check($sformatf("tbl%0d err", i), sb_err, tbl[i].e_err);
      @(negedge clk);
    end

    // Randomised phase against the reference model, small register window
    // so hazards, saturation and capacity limits occur often.
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    model_reset();
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      vec_t x;
      x = idle;
      x.rst  = ($urandom_range(0, 199) == 0);
      x.v    = ($urandom_range(0, 3) != 0);
      x.rs1  = $urandom_range(0, 4);
      x.u1   = $urandom_range(0, 1);
      x.rs2  = $urandom_range(0, 4);
      x.u2   = $urandom_range(0, 1);
      x.rd   = $urandom_range(0, 4);
      x.wr   = ($urandom_range(0, 4) != 0);
      x.wbv  = $urandom_range(0, 1);
      x.wbrd = $urandom_range(0, 4);
      x.fl   = ($urandom_range(0, 29) == 0);
      drive(x);
      #1;
      check("rnd ready", iss_ready, model_ready(x));
      check("rnd stall", dec_stall, x.v && !model_ready(x));
      check("rnd inflight", inflight, m_inf);
      check("rnd busy", sb_busy, m_drain || (m_inf != 0));
      check("rnd err", sb_err, m_err);
      model_step(x);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/beta_issue_scoreboard.md
# beta_issue_scoreboard

Register-hazard scoreboard and issue controller sitting between the decode stage and the execute stage. It tracks, per architectural register, how many issued instructions still owe a regfile write, and gates decode→execute issue on read-after-write hazards, in-flight capacity and flush draining. Writeback notifications from the execute/writeback path retire pending writes.

## Interface
- `Embedded`, default 0: 1 selects the 16-register profile; addresses ≥16 are ignored.
- `MaxInFlight`, default 4: maximum outstanding register writes, range 1..15.
- `CntWidth`, default 2: width of each per-register pending counter.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `iss_valid_i` in 1: decode presents an instruction.
- `iss_rs1_addr_i`, `iss_rs2_addr_i` in 5: source register addresses.
- `iss_rs1_used_i`, `iss_rs2_used_i` in 1: the source is actually read.
- `iss_rd_addr_i` in 5: destination register address.
- `iss_rd_wr_i` in 1: the instruction writes rd.
- `iss_ready_o` out 1: the instruction may issue this cycle. Issue is accepted when `iss_valid_i & iss_ready_o`.
- `dec_stall_o` out 1: `iss_valid_i & ~iss_ready_o`.
- `wb_valid_i` in 1: a regfile write completes this cycle.
- `wb_rd_addr_i` in 5: register being written.
- `flush_i` in 1: pipeline flush request.
- `inflight_o` out 4: outstanding write count.
- `sb_busy_o` out 1: state is not RUN, or `inflight_o` is not 0.
- `sb_err_o` out 1: sticky error; set by a writeback to a register whose counter is 0.

## Operation
- Per-register pending counter `cnt[r]`, width `CntWidth`. x0 never allocates and is never hazardous.
- In `Embedded` mode, addresses ≥16 behave exactly like x0.
- A source is hazardous if it is used, is nonzero, and `cnt[src] != 0`.
- `iss_ready_o` = state==RUN, and no hazardous source, and `inflight < MaxInFlight`, and `cnt[rd]` is not saturated. This holds whenever `iss_rd_wr_i` is set and rd≠0.
- Allocation: on an accepted issue with `iss_rd_wr_i` and rd≠0, `cnt[rd]` += 1 and `inflight` += 1.
- Retire: on `wb_valid_i` with rd≠0 and `cnt[rd]` != 0, `cnt[rd]` −= 1 and `inflight` −= 1.
- Writeback to x0 is ignored.
- Writeback to a counter at 0 changes no state and sets `sb_err_o`. `sb_err_o` clears only on reset.
- Same-cycle allocate and retire on the same register: the counter is unchanged and `inflight` is unchanged.
- Same-cycle allocate and retire on different registers: both counters update and `inflight` is unchanged.
- FSM states: RUN, DRAIN.
  - RUN→DRAIN when `flush_i` is high. Any issue presented in that cycle is refused, because `iss_ready_o` is forced to 0 while `flush_i` is high.
  - In DRAIN, `iss_ready_o`=0. Writebacks keep retiring. `flush_i` is ignored.
  - DRAIN→RUN on the first edge where `inflight`==0 after that cycle's update.

## Timing
- `iss_ready_o` and `dec_stall_o` are combinational from registered state plus the `iss_*` and `flush_i` inputs. There is no combinational path from `wb_*`.
- A writeback does not bypass: a RAW hazard cleared by a writeback in cycle N allows issue at the earliest in cycle N+1.
- Counter, `inflight`, FSM and `sb_err_o` updates take effect on the next rising edge.
- Reset values: all `cnt` = 0, `inflight_o` = 0, state RUN, `sb_err_o` = 0, `sb_busy_o` = 0, `dec_stall_o` = 0. `iss_ready_o` = 1 unless `flush_i` is high.
- Reset mid-operation discards all pending state in one cycle. Writebacks arriving after reset for pre-reset instructions set `sb_err_o`.
- Capacity full: with `inflight`==MaxInFlight and a same-cycle writeback, issue is still refused that cycle.

## Configuration
- `BETA_SB_WAW_CHECK_EN` defined: `iss_ready_o` additionally requires `cnt[rd]`==0 whenever rd is written. At most one write per register is outstanding, so counters never exceed 1.
- `BETA_SB_WAW_CHECK_EN` undefined: multiple outstanding writes to one register are allowed, up to 2^`CntWidth`−1. Writebacks are assumed to arrive in order.

## Structure
- Shared package `beta_pkg`:
  - `sb_state_t` enum (`SB_RUN`, `SB_DRAIN`).
  - `SB_NUM_REGS` helper (32 or 16).
  - `SB_INFLIGHT_W` = 4.
- Sub-module `beta_sb_regcnt`: the counter array. It takes allocate enable/address and retire enable/address. It outputs the counter value for three read addresses (rs1, rs2, rd), plus a `zero_retire` flag.
- The top holds the FSM, the `inflight` counter, the ready logic and `sb_err_o`.

## Test plan
- Issue `x5` write (`rd_wr`=1). Next cycle, present an instruction with rs1=5 used → `dec_stall_o`=1. Apply `wb` x5 in cycle N → `iss_ready_o`=1 in N+1 and `cnt[5]`=0.
- Issue with rs2=5 but `rs2_used`=0, while x5 is pending → accepted with no stall. Issue writing x0 → `inflight_o` unchanged.
- With MaxInFlight=4, issue 4 writes to x1..x4 → 5th issue stalls. `wb` x2 → 5th issue accepted next cycle and `inflight_o`=4.
- Same cycle: issue writes x7 while `wb` x7 retires a prior x7 write → `cnt[7]` stays 1 and `inflight_o` unchanged. With `BETA_SB_WAW_CHECK_EN`, that issue instead stalls.
- With 2 writes pending, pulse `flush_i` → state DRAIN and `iss_ready_o`=0. After 2 writebacks → RUN on the following edge and `sb_busy_o`=0.
- `wb` x9 with `cnt[9]`=0 → `sb_err_o`=1, stays 1 until `rst_i`. Asserting `rst_i` mid-DRAIN → RUN with all outputs at their reset values.
